// File: rtl/sobel_scan_ctrl_if.sv
// Handshake bundle between the Sobel scan controller, the upstream pixel
// source and the downstream window consumer.
interface sobel_scan_ctrl_if #(
   parameter int coord_width_p = 16
);
   logic                     start_i;
   logic                     in_valid_i;
   logic                     in_ready_o;
   logic                     shift_en_o;
   logic                     out_valid_o;
   logic                     out_ready_i;
   logic [coord_width_p-1:0] x_o;
   logic [coord_width_p-1:0] y_o;
   logic                     busy_o;
   logic                     frame_done_o;
   logic                     dbg_state_o;

   // Both channels are valid/ready: a beat transfers on a rising edge where
   // valid and ready are both high; valid and its payload hold until then.
   modport slave (
      input  start_i, in_valid_i, out_ready_i,
      output in_ready_o, shift_en_o, out_valid_o, x_o, y_o,
             busy_o, frame_done_o, dbg_state_o
   );

   modport master (
      output start_i, in_valid_i, out_ready_i,
      input  in_ready_o, shift_en_o, out_valid_o, x_o, y_o,
             busy_o, frame_done_o, dbg_state_o
   );
endinterface

// File: rtl/sobel_scan_ctrl.sv
// Raster-scan controller for a 3x3 Sobel window: counts accepted pixels and
// announces each complete window centre downstream, one cycle after its last pixel.
module sobel_scan_ctrl #(
   parameter int width_p       = 640,
   parameter int height_p      = 480,
   parameter int coord_width_p = 16
) (
   input logic              clk_i,
   input logic              reset_i,
   sobel_scan_ctrl_if.slave bus
);
   typedef enum logic {IDLE_S = 1'b0, ACTIVE_S = 1'b1} state_e;

   localparam logic [coord_width_p-1:0] last_col_c = coord_width_p'(width_p - 1);
   localparam logic [coord_width_p-1:0] last_row_c = coord_width_p'(height_p - 1);
   localparam logic [coord_width_p-1:0] one_c      = coord_width_p'(1);
   localparam logic [coord_width_p-1:0] two_c      = coord_width_p'(2);

   state_e                   state_q, state_d;
   logic [coord_width_p-1:0] col_q, col_d, row_q, row_d;
   logic [coord_width_p-1:0] x_q, x_d, y_q, y_d;
   logic                     out_valid_q, out_valid_d;
   logic                     frame_done_q, frame_done_d;
   logic                     in_ready, accept, last_pix, win_valid;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= IDLE_S;
         col_q        <= '0;
         row_q        <= '0;
         x_q          <= '0;
         y_q          <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         x_q          <= x_d;
         y_q          <= y_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      x_d          = x_q;
      y_d          = y_q;
      out_valid_d  = out_valid_q;
      frame_done_d = 1'b0;

      // A held window blocks upstream so the line buffers never overrun it.
      in_ready  = (state_q == ACTIVE_S) && (!out_valid_q || bus.out_ready_i);
      accept    = bus.in_valid_i && in_ready;
      last_pix  = (col_q == last_col_c) && (row_q == last_row_c);
      win_valid = (col_q >= two_c) && (row_q >= two_c);

      if (bus.out_ready_i) out_valid_d = 1'b0;

      unique case (state_q)
         IDLE_S: begin
            if (bus.start_i) begin
               state_d = ACTIVE_S;
               col_d   = '0;
               row_d   = '0;
            end
         end
         ACTIVE_S: begin
            if (accept) begin
               if (win_valid) begin
                  out_valid_d = 1'b1;
                  x_d         = col_q - one_c;
                  y_d         = row_q - one_c;
               end
               if (last_pix) begin
                  state_d      = IDLE_S;
                  frame_done_d = 1'b1;
                  col_d        = '0;
                  row_d        = '0;
               end else if (col_q == last_col_c) begin
                  col_d = '0;
                  row_d = row_q + one_c;
               end else begin
                  col_d = col_q + one_c;
               end
            end
         end
         default: state_d = IDLE_S;
      endcase
   end

   assign bus.in_ready_o   = in_ready;
   assign bus.shift_en_o   = accept;
   assign bus.out_valid_o  = out_valid_q;
   assign bus.x_o          = x_q;
   assign bus.y_o          = y_q;
   assign bus.busy_o       = (state_q == ACTIVE_S);
   assign bus.frame_done_o = frame_done_q;
   assign bus.dbg_state_o  = state_q;
endmodule

// File: tb/tb_sobel_scan_ctrl.sv
// Bench for sobel_scan_ctrl: directed 4x3 frames plus a randomized 12x8 frame
// checked against a raster-order window list.
module tb_sobel_scan_ctrl;
  localparam int W_B = 12;
  localparam int H_B = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sobel_scan_ctrl_if #(.coord_width_p(16)) a_if ();
  sobel_scan_ctrl_if #(.coord_width_p(16)) b_if ();

  sobel_scan_ctrl #(.width_p(4), .height_p(3), .coord_width_p(16)) dut_a (
    .clk_i(clk), .reset_i(rst), .bus(a_if.slave)
  );
  sobel_scan_ctrl #(.width_p(W_B), .height_p(H_B), .coord_width_p(16)) dut_b (
    .clk_i(clk), .reset_i(rst), .bus(b_if.slave)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(a_if.out_valid_o), 0);
    chk({tag, "_x"}, 32'(a_if.x_o), 0);
    chk({tag, "_y"}, 32'(a_if.y_o), 0);
    chk({tag, "_frame_done"}, 32'(a_if.frame_done_o), 0);
    chk({tag, "_in_ready"}, 32'(a_if.in_ready_o), 0);
    chk({tag, "_shift_en"}, 32'(a_if.shift_en_o), 0);
    chk({tag, "_busy"}, 32'(a_if.busy_o), 0);
  endtask

  // One 4x3 frame with in_valid held high; optional stall after the first
  // window, optional start held high, optional async reset after abort_at pixels.
  task automatic run_frame_a(input int stall, input bit hold_start, input int abort_at);
    int k, c, r, wins, cyc;
    k = 0; wins = 0; cyc = 0;
    a_if.start_i = 1'b1; a_if.in_valid_i = 1'b0; a_if.out_ready_i = 1'b1;
    step();
    chk("busy_after_start", 32'(a_if.busy_o), 1);
    a_if.start_i = hold_start;
    a_if.in_valid_i = 1'b1;
    while (k < 12 && cyc < 200) begin
      cyc++;
      #1;
      chk("in_ready_run", 32'(a_if.in_ready_o), 1);
      chk("shift_en_run", 32'(a_if.shift_en_o), 1);
      step();
      c = k % 4; r = k / 4; k++;
      if (c >= 2 && r >= 2) begin
        wins++;
        chk("win_valid", 32'(a_if.out_valid_o), 1);
        chk("win_x", 32'(a_if.x_o), 32'(c - 1));
        chk("win_y", 32'(a_if.y_o), 32'(r - 1));
        if (wins == 1 && stall > 0) begin
          a_if.out_ready_i = 1'b0;
          for (int s = 0; s < stall; s++) begin
            #1;
            chk("stall_in_ready", 32'(a_if.in_ready_o), 0);
            chk("stall_shift_en", 32'(a_if.shift_en_o), 0);
            step();
            chk("stall_hold_valid", 32'(a_if.out_valid_o), 1);
            chk("stall_hold_x", 32'(a_if.x_o), 1);
            chk("stall_hold_y", 32'(a_if.y_o), 1);
          end
          a_if.out_ready_i = 1'b1;
        end
      end else begin
        chk("no_win", 32'(a_if.out_valid_o), 0);
      end
      chk("frame_done", 32'(a_if.frame_done_o), 32'(k == 12));
      if (k == abort_at) begin
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        a_if.in_valid_i = 1'b0;
        a_if.start_i = 1'b0;
        step();
        rst = 1'b0;
        step();
        step();
        chk("abort_no_done", 32'(a_if.frame_done_o), 0);
        chk("abort_idle", 32'(a_if.busy_o), 0);
        return;
      end
    end
    a_if.start_i = 1'b0;
    a_if.in_valid_i = 1'b0;
    chk("pixels_accepted", 32'(k), 12);
    chk("window_count", 32'(wins), 2);
    chk("idle_after_frame", 32'(a_if.busy_o), 0);
    step();
    chk("out_valid_drained", 32'(a_if.out_valid_o), 0);
    chk("frame_done_pulse_end", 32'(a_if.frame_done_o), 0);
    chk("stays_idle", 32'(a_if.busy_o), 0);
  endtask

  initial begin
    int shifts, dones, cyc;
    logic [31:0] got, want;

    a_if.start_i = 1'b0; a_if.in_valid_i = 1'b0; a_if.out_ready_i = 1'b0;
    b_if.start_i = 1'b0; b_if.in_valid_i = 1'b0; b_if.out_ready_i = 1'b0;
    #12;
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Pixels offered in IDLE without start are refused.
    a_if.in_valid_i = 1'b1;
    a_if.out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("idle_in_ready", 32'(a_if.in_ready_o), 0);
      chk("idle_shift_en", 32'(a_if.shift_en_o), 0);
      step();
      chk("idle_busy", 32'(a_if.busy_o), 0);
    end
    a_if.in_valid_i = 1'b0;

    run_frame_a(0, 1'b0, 0);
    run_frame_a(5, 1'b0, 0);
    run_frame_a(0, 1'b1, 0);
    run_frame_a(0, 1'b0, 8);
    run_frame_a(0, 1'b0, 0);

    // Randomized frame on the 12x8 instance.
    for (int yy = 1; yy <= H_B - 2; yy++)
      for (int xx = 1; xx <= W_B - 2; xx++)
        exp_q.push_back({16'(xx), 16'(yy)});
    b_if.start_i = 1'b1;
    step();
    b_if.start_i = 1'b0;
    shifts = 0; dones = 0; cyc = 0;
    while ((dones == 0 || exp_q.size() > 0) && cyc < 5000) begin
      cyc++;
      b_if.in_valid_i  = ($urandom_range(0, 3) != 0);
      b_if.out_ready_i = ($urandom_range(0, 2) != 0);
      #1;
      if (b_if.shift_en_o) shifts++;
      if (b_if.out_valid_o && b_if.out_ready_i) begin
        got  = {b_if.x_o, b_if.y_o};
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hffff_ffff;
        chk("rand_window_xy", got, want);
      end
      step();
      if (b_if.frame_done_o) dones++;
    end
    b_if.in_valid_i = 1'b0;
    b_if.out_ready_i = 1'b1;
    step();
    chk("rand_windows_left", 32'(exp_q.size()), 0);
    chk("rand_shift_count", 32'(shifts), 32'(W_B * H_B));
    chk("rand_frame_done_count", 32'(dones), 1);
    chk("rand_idle", 32'(b_if.busy_o), 0);
    chk("rand_out_valid_clear", 32'(b_if.out_valid_o), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
